// File: rtl/dds_pkg.sv
// Shared DDS constants and loader state encoding.
package dds_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Saturating increment for a 0..DEPTH sample counter
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    localparam logic [ADDR_W:0] MAX = (ADDR_W+1)'(DEPTH);
    return (v == MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/wavetable_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
module wavetable_ram
  import dds_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // Write and read share the edge; the NBA gives old data on a same-address hit
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/wavetable_loader.sv
// Run-time wavetable writer: streams DEPTH samples into a RAM, ROM-style read port.
module wavetable_loader
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              load_busy,
  output logic              table_ready,
  output logic [ADDR_W:0]   load_count,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);
  loader_state_e     r_state, w_next;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W:0]   r_load_count;
  logic              r_rd_en;
  logic              w_hs, w_clr;
  logic [DATA_W-1:0] w_rdata;

  // Handshake qualifiers come straight from the state register
  assign s_ready     = (r_state == LOAD);
  assign load_busy   = (r_state == LOAD);
  assign table_ready = (r_state == DONE);
  assign w_hs        = s_valid & s_ready;
  assign load_count  = r_load_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state; w_clr restarts the write pointer and count on entry to LOAD
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: if (load_start) begin w_next = LOAD; w_clr = 1'b1; end
      LOAD: if (w_hs && r_waddr == ADDR_W'(DEPTH-1)) w_next = DONE;
      DONE: if (load_start) begin w_next = LOAD; w_clr = 1'b1; end
      default: w_next = IDLE;
    endcase
  end

  // Write pointer wraps naturally; count saturates at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr      <= '0;
      r_load_count <= '0;
    end else if (w_clr) begin
      r_waddr      <= '0;
      r_load_count <= '0;
    end else if (w_hs) begin
      r_waddr      <= r_waddr + 1'b1;
      r_load_count <= sat_inc(r_load_count);
    end
  end

  // Remember whether the table was complete when raddr was sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_en <= 1'b0;
    else        r_rd_en <= table_ready;
  end

  wavetable_ram #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (w_hs),
    .waddr (r_waddr),
    .wdata (s_data),
    .raddr (raddr),
    .rdata (w_rdata)
  );

  // RAM data register gated by a reset-able enable register: dout is 0 out of
  // reset and whenever the table was incomplete at the sampling edge, and the
  // RAM array itself needs no reset.
  assign dout = r_rd_en ? w_rdata : '0;
endmodule

// File: tb/tb_wavetable_loader.sv
// Self-checking bench for wavetable_loader: table-driven reads plus load sequences.
module tb_wavetable_loader;
  localparam int AW = 12;
  localparam int DW = 24;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          load_busy;
  logic          table_ready;
  logic [AW:0]   load_count;
  logic [AW-1:0] raddr;
  logic [DW-1:0] dout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;

  wavetable_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .load_busy(load_busy),
    .table_ready(table_ready), .load_count(load_count), .raddr(raddr), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample pattern: mode 0 = addr*0x1000, mode 1 = ~addr
  function automatic logic [DW-1:0] pat(input int mode, input int a);
    logic [DW-1:0] v;
    v = DW'(a);
    return (mode == 0) ? (v << 12) : ~v;
  endfunction

  // Scoreboarded read: expectation queued with the address, checked a cycle later
  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    raddr = a;
    sb.push_back(e);
    tick();
    chk(name, dout, sb.pop_front());
  endtask

  task automatic run_vecs(input string name, input vec_t v[]);
    foreach (v[i]) rd_chk($sformatf("%s[%0d]", name, i), v[i].addr, v[i].exp);
  endtask

  // Pulse load_start, then stream n samples; optional gaps and a stray load_start
  task automatic do_load(input int mode, input bit gaps, input int n, input int pulse_at,
                         input bit reload);
    int idx = 0;
    int cyc = 0;
    bit hs;
    raddr      = 12'h010;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_busy_on", load_busy, 1);
    chk("s_ready_on", s_ready, 1);
    if (reload) chk("table_ready_drop", table_ready, 0);
    while (idx < n && cyc < 30000) begin
      s_valid    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data     = pat(mode, idx);
      load_start = (idx == pulse_at && pulse_at >= 0);
      hs = s_valid && s_ready;
      tick();
      cyc++;
      load_start = 1'b0;
      if (hs) begin
        idx++;
        if (pulse_at >= 0 && (idx == pulse_at + 1 || idx == pulse_at + 2))
          chk($sformatf("count_after_start_%0d", idx), load_count, idx);
        if (idx == 10) chk("dout_zero_in_load", dout, 0);
      end
    end
    s_valid = 1'b0;
    if (cyc >= 30000) chk("load_timeout", cyc, 0);
    if (n == N) begin
      chk("done_table_ready", table_ready, 1);
      chk("done_busy", load_busy, 0);
      chk("done_s_ready", s_ready, 0);
      chk("done_count", load_count, N);
      chk("first_dout_zero", dout, 0);
    end else begin
      chk("partial_count", load_count, n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"}, load_busy, 0);
    chk({tag, "_table_ready"}, table_ready, 0);
    chk({tag, "_count"}, load_count, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    vec_t t0[];
    vec_t t1[];
    t0 = '{'{12'h010, 24'h010000}, '{12'h000, 24'h000000}, '{12'h001, 24'h001000},
           '{12'hFFF, 24'hFFF000}, '{12'h800, 24'h800000}, '{12'h123, 24'h123000}};
    t1 = '{'{12'hFFF, 24'hFFF000}, '{12'h000, 24'hFFFFFF}, '{12'h010, 24'hFFFFEF},
           '{12'h555, 24'hFFFAAA}, '{12'h010, 24'hFFFFEF}};

    rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = '0; raddr = '0;

    // 1: reset state for a couple of raddr values
    #12;
    chk_reset_outputs("rst");
    raddr = 12'hABC;
    #10;
    chk("rst_dout_any_addr", dout, 0);
    rst_n = 1'b1;
    tick();
    rd_chk("idle_dout", 12'h010, 24'h0);

    // 2: full back-to-back load, then table-driven reads
    do_load(0, 1'b0, N, -1, 1'b0);
    run_vecs("tbl0", t0);

    // 3: after DONE, a valid source must be ignored and the RAM left alone
    s_valid = 1'b1; s_data = 24'hABCDEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("done_no_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    chk("done_count_hold", load_count, N);
    rd_chk("ram_unchanged_0", 12'h000, 24'h000000);
    rd_chk("ram_unchanged_1", 12'h001, 24'h001000);

    // 4: reload with random gaps and ~addr data
    do_load(1, 1'b1, N, -1, 1'b1);
    run_vecs("tbl1", t1);

    // Async reset mid-cycle with a complete table: outputs drop at once
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    #2 rst_n = 1'b1;
    tick();
    rd_chk("post_rst_dout", 12'h010, 24'h0);

    // 5: reset after 100 samples, then a fresh load
    do_load(0, 1'b0, 100, -1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midload");
    #2 rst_n = 1'b1;
    tick();

    // 6: fresh load with a stray load_start at sample 50
    do_load(0, 1'b0, N, 50, 1'b0);
    run_vecs("tbl2", t0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
